// File: rtl/mul_accumulator.sv
// mul_accumulator: sums a packet of product terms (with overflow flags) from
// multiplier32 into one result, presented on a valid/ready output until accepted.
module mul_accumulator #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CNT_W    = 16,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [WIDTH-1:0] prod_data,
    input  logic             prod_ovf,
    input  logic             prod_last,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [WIDTH-1:0] acc_data,
    output logic             acc_ovf,
    output logic [CNT_W-1:0] acc_count,
    output logic             busy
);

    localparam int unsigned SUM_W = WIDTH + 1;
    localparam logic [WIDTH-1:0] ACC_MAX = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               sticky_q,    sticky_d;
    logic               acc_valid_q, acc_valid_d;
    logic [WIDTH-1:0]   acc_data_q,  acc_data_d;
    logic               acc_ovf_q,   acc_ovf_d;
    logic [CNT_W-1:0]   acc_count_q, acc_count_d;
    logic               busy_q,      busy_d;

    logic               xfer;
    logic [SUM_W-1:0]   sum;
    logic               carry;
    logic [WIDTH-1:0]   acc_upd;
    logic [CNT_W-1:0]   cnt_upd;
    logic               sticky_upd;

    // Upstream may push whenever no result is waiting; pure decode of state.
    assign prod_ready = (state_q != ST_HOLD);
    assign xfer       = prod_valid & prod_ready;

    // Per-term datapath: widened add, optional clamp, saturating term count.
    always_comb begin
        sum        = {1'b0, acc_q} + {1'b0, prod_data};
        carry      = sum[WIDTH];
        sticky_upd = sticky_q | prod_ovf | carry;
        if (SATURATE && (carry || prod_ovf)) begin
            acc_upd = ACC_MAX;
        end else begin
            acc_upd = sum[WIDTH-1:0];
        end
        if (cnt_q == CNT_MAX) begin
            cnt_upd = cnt_q;
        end else begin
            cnt_upd = cnt_q + CNT_W'(1);
        end
    end

    // Next-state and register updates for the packet FSM.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        acc_valid_d = acc_valid_q;
        acc_data_d  = acc_data_q;
        acc_ovf_d   = acc_ovf_q;
        acc_count_d = acc_count_q;

        unique case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (xfer) begin
                    if (prod_last) begin
                        // Close the packet: publish the result and clear internal state.
                        acc_data_d  = acc_upd;
                        acc_ovf_d   = sticky_upd;
                        acc_count_d = cnt_upd;
                        acc_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        sticky_d    = 1'b0;
                        state_d     = ST_HOLD;
                    end else begin
                        acc_d    = acc_upd;
                        cnt_d    = cnt_upd;
                        sticky_d = sticky_upd;
                        state_d  = ST_ACCUM;
                    end
                end
            end
            ST_HOLD: begin
                // Result data is left in place after the accept; only valid drops.
                if (acc_valid_q && acc_ready) begin
                    acc_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                acc_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset discards any open packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_data_q  <= '0;
            acc_ovf_q   <= 1'b0;
            acc_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            acc_valid_q <= acc_valid_d;
            acc_data_q  <= acc_data_d;
            acc_ovf_q   <= acc_ovf_d;
            acc_count_q <= acc_count_d;
            busy_q      <= busy_d;
        end
    end

    assign acc_valid = acc_valid_q;
    assign acc_data  = acc_data_q;
    assign acc_ovf   = acc_ovf_q;
    assign acc_count = acc_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed bench for mul_accumulator: three instances driven in lockstep
// (wrapping, saturating, and a 2-bit term counter) against hand-computed results.
module tb_mul_accumulator;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             prod_valid;
    logic [WIDTH-1:0] prod_data;
    logic             prod_ovf;
    logic             prod_last;
    logic             acc_ready;

    logic             prod_ready,   s_prod_ready,   c_prod_ready;
    logic             acc_valid,    s_acc_valid,    c_acc_valid;
    logic [WIDTH-1:0] acc_data,     s_acc_data,     c_acc_data;
    logic             acc_ovf,      s_acc_ovf,      c_acc_ovf;
    logic [CNT_W-1:0] acc_count,    s_acc_count;
    logic [1:0]       c_acc_count;
    logic             busy,         s_busy,         c_busy;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    mul_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SATURATE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data),
        .prod_ovf(prod_ovf), .prod_last(prod_last),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
        .acc_ovf(acc_ovf), .acc_count(acc_count), .busy(busy)
    );

    mul_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .prod_valid(prod_valid), .prod_ready(s_prod_ready), .prod_data(prod_data),
        .prod_ovf(prod_ovf), .prod_last(prod_last),
        .acc_valid(s_acc_valid), .acc_ready(acc_ready), .acc_data(s_acc_data),
        .acc_ovf(s_acc_ovf), .acc_count(s_acc_count), .busy(s_busy)
    );

    mul_accumulator #(.WIDTH(WIDTH), .CNT_W(2), .SATURATE(1'b0)) dut_cnt (
        .clk(clk), .rst_n(rst_n),
        .prod_valid(prod_valid), .prod_ready(c_prod_ready), .prod_data(prod_data),
        .prod_ovf(prod_ovf), .prod_last(prod_last),
        .acc_valid(c_acc_valid), .acc_ready(acc_ready), .acc_data(c_acc_data),
        .acc_ovf(c_acc_ovf), .acc_count(c_acc_count), .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one term and hold it until the edge that transfers it.
    task automatic send_term(input logic [WIDTH-1:0] d, input logic ovf, input logic last);
        int n;
        prod_valid = 1'b1;
        prod_data  = d;
        prod_ovf   = ovf;
        prod_last  = last;
        n = 0;
        while (!prod_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check("send_timeout", 64'(prod_ready), 64'd1);
        @(posedge clk); #1;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        prod_ovf   = 1'b0;
    endtask

    // Pulse acc_ready for one edge and confirm the handshake completes.
    task automatic accept(input string tag);
        acc_ready = 1'b1;
        @(posedge clk); #1;
        acc_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(acc_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(prod_ready), 64'd1);
    endtask

    initial begin
        int t1;
        int t2;
        rst_n      = 1'b0;
        prod_valid = 1'b0;
        prod_data  = '0;
        prod_ovf   = 1'b0;
        prod_last  = 1'b0;
        acc_ready  = 1'b0;
        #1;
        check("rst_valid", 64'(acc_valid), 64'd0);
        check("rst_data",  64'(acc_data),  64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_ready", 64'(prod_ready), 64'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: reset discards an open packet
        send_term(32'd5, 1'b0, 1'b0);
        check("t1_busy_open", 64'(busy), 64'd1);
        send_term(32'd7, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("t1_rst_data",  64'(acc_data),  64'd0);
        check("t1_rst_count", 64'(acc_count), 64'd0);
        check("t1_rst_ovf",   64'(acc_ovf),   64'd0);
        check("t1_rst_valid", 64'(acc_valid), 64'd0);
        check("t1_rst_busy",  64'(busy),      64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_term(32'd9, 1'b0, 1'b1);
        check("t1_data",  64'(acc_data),  64'd9);
        check("t1_count", 64'(acc_count), 64'd1);
        accept("t1");

        // 2: three terms back to back, result one cycle after the last
        send_term(32'd5, 1'b0, 1'b0);
        send_term(32'd7, 1'b0, 1'b0);
        send_term(32'h10, 1'b0, 1'b1);
        check("t2_valid", 64'(acc_valid), 64'd1);
        check("t2_data",  64'(acc_data),  64'h1C);
        check("t2_count", 64'(acc_count), 64'd3);
        check("t2_ovf",   64'(acc_ovf),   64'd0);
        check("t2_sat_data", 64'(s_acc_data), 64'h1C);
        accept("t2");

        // 3: carry out of the accumulator, wrap vs clamp
        send_term(32'hFFFF_FFF0, 1'b0, 1'b0);
        send_term(32'h20, 1'b0, 1'b1);
        check("t3_wrap_data", 64'(acc_data),   64'h10);
        check("t3_wrap_ovf",  64'(acc_ovf),    64'd1);
        check("t3_sat_data",  64'(s_acc_data), 64'hFFFF_FFFF);
        check("t3_sat_ovf",   64'(s_acc_ovf),  64'd1);
        accept("t3");

        // 4: product overflow is sticky within a packet only
        send_term(32'd1, 1'b0, 1'b0);
        send_term(32'd2, 1'b1, 1'b0);
        send_term(32'd3, 1'b0, 1'b1);
        check("t4_data", 64'(acc_data), 64'd6);
        check("t4_ovf",  64'(acc_ovf),  64'd1);
        accept("t4");
        send_term(32'd4, 1'b0, 1'b1);
        check("t4_next_data", 64'(acc_data), 64'd4);
        check("t4_next_ovf",  64'(acc_ovf),  64'd0);
        accept("t4n");

        // 5: result held under backpressure while upstream keeps pushing
        send_term(32'h55, 1'b0, 1'b1);
        prod_valid = 1'b1;
        prod_data  = 32'hDEAD;
        prod_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t5_ready_low", 64'(prod_ready), 64'd0);
            check("t5_hold_data", 64'(acc_data),   64'h55);
            check("t5_hold_valid", 64'(acc_valid), 64'd1);
            check("t5_hold_count", 64'(acc_count), 64'd1);
        end
        acc_ready = 1'b1;
        @(posedge clk); #1;
        acc_ready  = 1'b0;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        check("t5_valid_drop", 64'(acc_valid), 64'd0);
        check("t5_ready_back", 64'(prod_ready), 64'd1);
        check("t5_data_kept",  64'(acc_data),  64'h55);
        @(posedge clk); #1;
        check("t5_no_xfer", 64'(acc_valid), 64'd0);

        // 6: back-to-back single-term packets with the consumer always ready
        acc_ready = 1'b1;
        send_term(32'h1234, 1'b0, 1'b1);
        t1 = cyc;
        check("t6_a_valid", 64'(acc_valid), 64'd1);
        check("t6_a_data",  64'(acc_data),  64'h1234);
        check("t6_a_count", 64'(acc_count), 64'd1);
        send_term(32'hABCD, 1'b0, 1'b1);
        t2 = cyc;
        check("t6_b_valid", 64'(acc_valid), 64'd1);
        check("t6_b_data",  64'(acc_data),  64'hABCD);
        check("t6_b_count", 64'(acc_count), 64'd1);
        check("t6_spacing", 64'(t2 - t1),   64'd2);
        @(posedge clk); #1;
        acc_ready = 1'b0;
        check("t6_idle", 64'(busy), 64'd0);

        // Term counter saturates without raising overflow (2-bit counter instance)
        for (int i = 1; i <= 5; i++) begin
            send_term(WIDTH'(i), 1'b0, (i == 5));
        end
        check("cnt_main",     64'(acc_count),   64'd5);
        check("cnt_main_sum", 64'(acc_data),    64'd15);
        check("cnt_sat",      64'(c_acc_count), 64'd3);
        check("cnt_sat_ovf",  64'(c_acc_ovf),   64'd0);
        check("cnt_sat_sum",  64'(c_acc_data),  64'd15);
        accept("cnt");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
